bus_rr_arbiter: RTL
===================

// Module: bus_rr_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one DATA_W-bit bus between NUM_REQ requesters.
//   Each requester drives bursts of beats over a valid/ready handshake.
//   A granted requester keeps the bus until its last beat, so bursts never interleave.
//   Sits between the per-lane generate blocks and the shared bus register.
//   The output is registered: 1-cycle latency, 1 beat/cycle sustained.
//
// PARAMETERS
//   NUM_REQ    8    number of requesters (>=2)
//   DATA_W     32   bus width in bits
//   MAX_BURST  16   beats per grant before forced release (>=1)
//
// PORTS
//   clk           in   1                  clock, all logic on rising edge
//   rst           in   1                  synchronous reset, active-high
//   req_valid     in   NUM_REQ            per-requester beat valid
//   req_data      in   NUM_REQ*DATA_W     requester i occupies bits [i*DATA_W +: DATA_W]
//   req_last      in   NUM_REQ            final beat of the burst
//   req_ready     out  NUM_REQ            beat accepted (combinational)
//   out_valid     out  1                  registered output beat valid
//   out_data      out  DATA_W             registered output data
//   out_last      out  1                  registered end-of-burst
//   out_src       out  $clog2(NUM_REQ)    index of the requester that sent this beat
//   out_ready     in   1                  downstream accept
//   busy          out  1                  1 while a multi-beat burst holds the lock
//   err_trunc     out  1                  1-cycle pulse: a burst was cut at MAX_BURST
//
// BEHAVIOUR
//   - Reset values:
//       - out_valid, out_data, out_last, out_src, busy, err_trunc = 0.
//       - req_ready = 0 while rst is high.
//       - Internal state: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
//   - can_acc = !out_valid || out_ready.
//     A transfer is req_valid[i] && req_ready[i]; at most one req_ready bit is high per cycle.
//   - State IDLE:
//       - Winner w = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ-1 -> 0.
//       - req_ready[w] = can_acc.
//       - When w transfers with req_last=1 (or MAX_BURST==1): stay IDLE, rr_ptr <= (w+1) mod NUM_REQ.
//       - When w transfers with req_last=0: go to LOCKED, owner <= w, burst_cnt <= 1.
//   - State LOCKED:
//       - req_ready[owner] = can_acc; every other requester sees req_ready = 0.
//       - If the owner deasserts req_valid, the lock holds and no beats pass. No timeout.
//       - Each owner transfer increments burst_cnt.
//       - A transfer with req_last=1 returns to IDLE and sets rr_ptr <= (owner+1) mod NUM_REQ.
//       - A transfer with req_last=0 while burst_cnt==MAX_BURST-1 is forced closed:
//           - out_last is registered as 1 for that beat.
//           - err_trunc pulses high the next cycle.
//           - state -> IDLE, rr_ptr advances past owner.
//   - Output register, on each transfer at edge t:
//       - out_valid=1 from t+1.
//       - out_data, out_last, out_src take the transferred beat's values.
//   - Output register with no transfer: if out_ready, out_valid <= 0; data fields hold their values.
//   - Output register while stalled: out_valid && !out_ready holds all outputs stable and blocks new grants.
//   - busy = (state==LOCKED), registered.
//   - The pointer advances only when a burst completes. A requester with no transfer never moves rr_ptr.
//   - A requester granted in IDLE may withdraw before transfer. Arbitration re-evaluates every cycle.
//   - Reset mid-burst: the lock is dropped, the pending output beat is discarded, and all outputs return to reset values the same edge.
//
// TESTING
//   - Reset then idle:
//       - Stimulus: rst=1 for 2 cycles, then all req_valid=0.
//       - Required: out_valid=0, busy=0, req_ready=0 throughout.
//   - Fairness:
//       - Stimulus: all 8 requesters hold single-beat bursts, out_ready=1.
//       - Required: out_src sequence 0,1,...,7,0 and one beat every cycle after 1-cycle latency.
//   - Lock:
//       - Stimulus: req 2 sends a 4-beat burst (data 0xA0..0xA3) while req 3 is valid.
//       - Required: out_src=2 for 4 beats, busy=1 for 3 cycles, then req 3 is granted.
//   - Backpressure:
//       - Stimulus: out_ready=0 for 5 cycles mid-burst.
//       - Required: out_data stable, req_ready=0, and no beat lost or duplicated after release.
//   - Truncation:
//       - Stimulus: MAX_BURST=16, req 5 sends 20 beats without last.
//       - Required: beat 16 has out_last=1, err_trunc pulses once, and the next grant goes to req 6 if valid.
//   - Mid-burst reset:
//       - Stimulus: rst=1 during beat 2 of a burst from req 7.
//       - Required: out_valid=0, busy=0 next cycle, and first post-reset grant starts search at req 0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: NUM_REQ burst sources share one registered DATA_W-bit output bus.
// Latency: 1 cycle from accepted beat to out_valid; sustains 1 beat/cycle.
// Backpressure: out_valid && !out_ready freezes the output register and drops every req_ready.
//
// Ports:
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   req_valid/data/last   per-requester beat; requester i uses req_data[i*DATA_W +: DATA_W]
//   req_ready             combinational accept, at most one bit high per cycle
//   out_valid/data/last   registered output beat, out_src = index of the sending requester
//   out_ready             downstream accept
//   busy                  high while a multi-beat burst holds the lock
//   err_trunc             one-cycle pulse after a burst was cut at MAX_BURST beats

module bus_rr_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [$clog2(NUM_REQ)-1:0]  out_src,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        err_trunc
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] TRUNC_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   owner_q,     owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;
    logic [IDX_W-1:0]   out_src_q,   out_src_d;
    logic               err_trunc_q, err_trunc_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic               can_acc;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    int                 cand_i;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_vld;
    logic               grant_vld;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic               xfer;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // The output register can take a beat when it is empty or being drained.
    assign can_acc = !out_valid_q || out_ready;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
    // The wrap is done on an int so non-power-of-two NUM_REQ works too.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_i    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_i = int'(rr_ptr_q) + k;
            if (cand_i >= NUM_REQ) begin
                cand_i = cand_i - NUM_REQ;
            end
            cand = IDX_W'(cand_i);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // While locked only the owner may talk; its ready tracks can_acc even
    // when it has paused, so the lock is held without a timeout.
    always_comb begin
        if (state_q == LOCKED) begin
            sel_idx   = owner_q;
            sel_vld   = req_valid[owner_q];
            grant_vld = 1'b1;
        end else begin
            sel_idx   = win_idx;
            sel_vld   = win_found;
            grant_vld = win_found;
        end
    end

    assign sel_data = req_data[sel_idx*DATA_W +: DATA_W];
    assign sel_last = req_last[sel_idx];
    assign xfer     = !rst && can_acc && sel_vld;

    always_comb begin
        req_ready = '0;
        if (!rst && can_acc && grant_vld) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        err_trunc_d = 1'b0;
        // A drained beat clears valid; data fields keep their last value.
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = sel_idx;

            if (state_q == IDLE) begin
                if (sel_last || (MAX_BURST == 1)) begin
                    // Single-beat burst: done immediately, pointer moves past winner.
                    out_last_d  = 1'b1;
                    rr_ptr_d    = next_idx(sel_idx);
                    err_trunc_d = !sel_last;
                end else begin
                    out_last_d  = 1'b0;
                    state_d     = LOCKED;
                    owner_d     = sel_idx;
                    burst_cnt_d = CNT_W'(1);
                end
            end else begin
                burst_cnt_d = burst_cnt_q + 1'b1;
                if (sel_last) begin
                    out_last_d  = 1'b1;
                    state_d     = IDLE;
                    rr_ptr_d    = next_idx(owner_q);
                    burst_cnt_d = '0;
                end else if (burst_cnt_q == TRUNC_CNT) begin
                    // Burst hit MAX_BURST beats: close it on this beat and flag it.
                    out_last_d  = 1'b1;
                    err_trunc_d = 1'b1;
                    state_d     = IDLE;
                    rr_ptr_d    = next_idx(owner_q);
                    burst_cnt_d = '0;
                end else begin
                    out_last_d  = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == LOCKED);
    assign err_trunc = err_trunc_q;

    // ------------------------------------------------------------------
    // Properties
    // ------------------------------------------------------------------
    a_one_grant : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

    a_stall_hold : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

endmodule
